// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 64-bit core's branch resolution logic:
//   - op_e    : operation class carried on op_i (none / branch / JAL / JALR)
//   - F3_*    : branch condition encodings carried on funct3_i
//   - state_e : squash FSM states of branch_resolve_stage
// ---------------------------------------------------------------------------
package core_pkg;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_BR   = 2'b01,
      OP_JAL  = 2'b10,
      OP_JALR = 2'b11
   } op_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic {
      RUN    = 1'b0,
      SHADOW = 1'b1
   } state_e;

endpackage

// File: rtl/branch_cmp.sv
// ---------------------------------------------------------------------------
// branch_cmp
// Purely combinational branch condition evaluator.
// Ports:
//   rs1_i, rs2_i : operands compared by the branch
//   funct3_i     : condition select (EQ/NE/LT/GE/LTU/GEU)
//   cond_o       : condition holds (always 0 for reserved encodings)
//   illegal_o    : funct3_i is one of the reserved encodings 010/011
// ---------------------------------------------------------------------------
module branch_cmp
   import core_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [DATA_W-1:0] rs1_i,
   input  logic [DATA_W-1:0] rs2_i,
   input  logic [2:0]        funct3_i,
   output logic              cond_o,
   output logic              illegal_o
);

   // Reserved encodings fall into the default arm: never taken, flagged illegal.
   always_comb begin
      cond_o    = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_BEQ:  cond_o = (rs1_i == rs2_i);
         F3_BNE:  cond_o = (rs1_i != rs2_i);
         F3_BLT:  cond_o = ($signed(rs1_i) <  $signed(rs2_i));
         F3_BGE:  cond_o = ($signed(rs1_i) >= $signed(rs2_i));
         F3_BLTU: cond_o = (rs1_i <  rs2_i);
         F3_BGEU: cond_o = (rs1_i >= rs2_i);
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_resolve_stage.sv
// ---------------------------------------------------------------------------
// branch_resolve_stage
// Registered branch/jump resolution stage. Computes the redirect target and
// link address for each accepted instruction, evaluates the branch condition
// and emits one registered record per instruction over valid/ready. After
// every taken redirect the next SHADOW_N accepted inputs are wrong-path and
// are consumed silently. A saturating counter tracks emitted taken redirects.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   valid_i / ready_o   : input handshake
//   pc_i, offset_i      : instruction PC and pre-doubled branch/JAL offset
//   imm_i, rs1_i, rs2_i : JALR immediate and register operands
//   funct3_i, op_i      : branch condition and operation class
//   flush_i             : drop the held output and the same-cycle input
//   valid_o / ready_i   : output handshake
//   redirect_o, target_o, link_o, err_o : registered result record
//   taken_cnt_o         : saturating count of emitted taken redirects
// ---------------------------------------------------------------------------
module branch_resolve_stage
   import core_pkg::*;
#(
   parameter int DATA_W   = 64,
   parameter int SHADOW_N = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] offset_i,
   input  logic [DATA_W-1:0] imm_i,
   input  logic [DATA_W-1:0] rs1_i,
   input  logic [DATA_W-1:0] rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [1:0]        op_i,
   input  logic              flush_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              redirect_o,
   output logic [DATA_W-1:0] target_o,
   output logic [DATA_W-1:0] link_o,
   output logic              err_o,
   output logic [31:0]       taken_cnt_o
);

   localparam int              SQ_W      = (SHADOW_N < 2) ? 1 : $clog2(SHADOW_N + 1);
   localparam logic [SQ_W-1:0] SQ_LOAD   = SQ_W'(SHADOW_N);
   localparam bit              SHADOW_EN = (SHADOW_N > 0);
   localparam logic [DATA_W-1:0] JALR_MASK = {{(DATA_W-1){1'b1}}, 1'b0};

   op_e               op;
   logic              cond;
   logic              illegal;
   logic [DATA_W-1:0] pcTarget;
   logic [DATA_W-1:0] jalrTarget;
   logic              redirectNew;
   logic              errNew;
   logic [DATA_W-1:0] targetNew;
   logic              accept;
   logic              emit;

   state_e            state_q, state_d;
   logic [SQ_W-1:0]   sq_q, sq_d;
   logic              valid_q, valid_d;
   logic              redirect_q, redirect_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] target_q, target_d;
   logic [DATA_W-1:0] link_q, link_d;
   logic [31:0]       takenCnt_q, takenCnt_d;

   assign op = op_e'(op_i);

   branch_cmp #(.DATA_W(DATA_W)) u_cmp (
      .rs1_i     (rs1_i),
      .rs2_i     (rs2_i),
      .funct3_i  (funct3_i),
      .cond_o    (cond),
      .illegal_o (illegal)
   );

   // Both targets are computed every cycle; the op class picks one.
   // The PC-relative sum doubles as the don't-care target for OP_NONE.
   assign pcTarget   = pc_i + offset_i;
   assign jalrTarget = (rs1_i + imm_i) & JALR_MASK;

   always_comb begin
      redirectNew = 1'b0;
      errNew      = 1'b0;
      targetNew   = pcTarget;
      case (op)
         OP_BR: begin
            redirectNew = cond;
            errNew      = illegal;
         end
         OP_JAL:  redirectNew = 1'b1;
         OP_JALR: begin
            redirectNew = 1'b1;
            targetNew   = jalrTarget;
         end
         default: ;
      endcase
   end

   assign ready_o = !valid_q || ready_i;
   assign accept  = valid_i && ready_o && !flush_i;
   // Inputs accepted while in SHADOW are wrong-path and never reach the output.
   assign emit    = accept && (state_q == RUN);

   // Squash FSM: flush always returns to RUN; in SHADOW each accepted input
   // burns one squash slot and the last slot drops back to RUN.
   always_comb begin
      state_d = state_q;
      sq_d    = sq_q;
      if (flush_i) begin
         state_d = RUN;
         sq_d    = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (SHADOW_EN && emit && redirectNew) begin
                  state_d = SHADOW;
                  sq_d    = SQ_LOAD;
               end
            end
            SHADOW: begin
               if (accept) begin
                  if (sq_q == SQ_W'(1)) begin
                     state_d = RUN;
                     sq_d    = '0;
                  end else begin
                     sq_d = sq_q - SQ_W'(1);
                  end
               end
            end
            default: begin
               state_d = RUN;
               sq_d    = '0;
            end
         endcase
      end
   end

   // Output record: flush kills it, a new emit replaces it, a plain handshake
   // empties it; otherwise every field holds so a stalled consumer sees stable data.
   always_comb begin
      valid_d    = valid_q;
      redirect_d = redirect_q;
      err_d      = err_q;
      target_d   = target_q;
      link_d     = link_q;
      if (flush_i) begin
         valid_d = 1'b0;
      end else if (emit) begin
         valid_d    = 1'b1;
         redirect_d = redirectNew;
         err_d      = errNew;
         target_d   = targetNew;
         link_d     = pc_i + DATA_W'(4);
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Taken counter sticks at all-ones instead of wrapping.
   always_comb begin
      takenCnt_d = takenCnt_q;
      if (emit && redirectNew && (takenCnt_q != 32'hFFFF_FFFF)) begin
         takenCnt_d = takenCnt_q + 32'd1;
      end
   end

   // State and output record registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= RUN;
         sq_q       <= '0;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         err_q      <= 1'b0;
         target_q   <= '0;
         link_q     <= '0;
      end else begin
         state_q    <= state_d;
         sq_q       <= sq_d;
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         err_q      <= err_d;
         target_q   <= target_d;
         link_q     <= link_d;
      end
   end

   // Taken counter register; flush deliberately leaves it alone.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         takenCnt_q <= '0;
      end else begin
         takenCnt_q <= takenCnt_d;
      end
   end

   assign valid_o     = valid_q;
   assign redirect_o  = redirect_q;
   assign err_o       = err_q;
   assign target_o    = target_q;
   assign link_o      = link_q;
   assign taken_cnt_o = takenCnt_q;

endmodule

// File: doc/branch_resolve_stage.md
# branch_resolve_stage

Registered branch/jump resolution stage for the 64-bit core. It sits directly downstream of `Shift_Left_One_64`: it consumes the already-doubled branch/JAL offset, adds it to the PC, and evaluates the branch condition. It emits one registered redirect/target/link record per instruction over a valid/ready handshake. It then squashes a fixed number of wrong-path instructions after every taken redirect and keeps a saturating taken-redirect counter.

## Interface
- `DATA_W`, 64, datapath width
- `SHADOW_N`, 2, wrong-path inputs squashed after a taken redirect (0 = none)
- `clk_i` input 1 clock
- `rst_i` input 1 synchronous active-high reset
- `valid_i` input 1 input record valid
- `ready_o` output 1 stage can accept
- `pc_i` input DATA_W PC of the instruction
- `offset_i` input DATA_W branch/JAL offset, already shifted left by one
- `imm_i` input DATA_W unshifted I-type immediate (JALR)
- `rs1_i`, `rs2_i` input DATA_W operands
- `funct3_i` input 3 branch condition
- `op_i` input 2 00 none, 01 branch, 10 JAL, 11 JALR
- `flush_i` input 1 kill pending and incoming work
- `valid_o` output 1 result valid
- `ready_i` input 1 consumer accepts
- `redirect_o` output 1 fetch must redirect
- `target_o` output DATA_W redirect target
- `link_o` output DATA_W pc+4
- `err_o` output 1 illegal funct3 (010/011) on a branch
- `taken_cnt_o` output 32 accepted taken redirects, saturating

## Operation
- `ready_o = !valid_o || ready_i`. Input is accepted when `valid_i && ready_o && !flush_i`.
- Branch conditions by `funct3_i`:
  - 000 EQ, 001 NE
  - 100 LT signed, 101 GE signed
  - 110 LTU, 111 GEU
  - 010/011 not taken, and `err_o=1`
- Target:
  - branch and JAL: `pc_i + offset_i`
  - JALR: `(rs1_i + imm_i) & ~1`
  - all sums modulo 2^64; wrap-around is silent
- `link_o = pc_i + 4`. `redirect_o` = (branch && cond) || JAL || JALR.
- For `op=00`, output `redirect_o=0`; target is don't-care but driven as `pc_i + offset_i`.
- FSM, states RUN and SHADOW, with a squash counter `sq`:
  - RUN: an accepted record with `redirect=1` and `SHADOW_N>0` loads `sq=SHADOW_N` and moves to SHADOW.
  - SHADOW: each accepted input is consumed (`ready_o` as normal) but produces no output, does not count, and sets no `err_o`. Decrement `sq`; at 1 -> RUN.
- `taken_cnt_o` increments on each accepted, non-squashed record with `redirect=1`. It holds at 0xFFFF_FFFF.
- `flush_i`: `valid_o` clears next cycle; the same-cycle input is dropped; FSM returns to RUN, `sq=0`. Flush does not clear `taken_cnt_o`.

## Timing
- Latency 1 cycle: record accepted at edge N is visible at `valid_o` after edge N.
- Output fields stay stable while `valid_o && !ready_i`.
- Full throughput: back-to-back accept when `ready_i=1`.
- Simultaneous events:
  - flush + accept: flush wins
  - flush + output handshake: output counts as consumed and `valid_o` goes 0
  - `ready_i=1` with new accept: output replaced in the same edge
- Reset (also mid-operation):
  - `valid_o`, `redirect_o`, `err_o` = 0
  - `target_o`, `link_o` = 0
  - `taken_cnt_o` = 0
  - FSM RUN, `sq=0`
  - `ready_o=1` the cycle after reset

## Structure
- Shared package `core_pkg`: `op_i` encodings (`OP_NONE`, `OP_BR`, `OP_JAL`, `OP_JALR`), funct3 constants (`F3_BEQ`…`F3_BGEU`), FSM state typedef.
- One combinational sub-module, `branch_cmp` (rs1, rs2, funct3 -> cond, illegal).
- Adders, FSM and output register live in the top module.

## Test plan
- BEQ, `pc=0x1000`, `offset=0x20`, `rs1=rs2=5`, SHADOW_N=0 -> next cycle `valid_o=1`, `redirect_o=1`, `target_o=0x1020`, `link_o=0x1004`, `taken_cnt_o=1`.
- BLT vs BLTU with `rs1=0xFFFF_FFFF_FFFF_FFFF`, `rs2=1` -> BLT taken, BLTU not taken. JALR with `rs1=0x2001`, `imm=0x10` -> target 0x2010.
- JAL at `pc=0xFFFF_FFFF_FFFF_FFF0`, `offset=0x20` -> target 0x10 (wrap). Then 3 more inputs with SHADOW_N=2 -> first two squashed (no `valid_o`), third emitted.
- `ready_i=0` for 4 cycles with `valid_o=1` -> outputs stable, `ready_o=0`, no inputs lost. Release -> back-to-back records at 1/cycle.
- `flush_i` asserted with `valid_o=1`, in SHADOW, and `valid_i=1` -> next cycle `valid_o=0`, FSM RUN, flushed input never appears.
- funct3=010 branch -> `err_o=1`, `redirect_o=0`. Force `taken_cnt_o` near saturation with 2 more JALs -> holds 0xFFFF_FFFF. Reset mid-stall -> all outputs 0.
